l1_lc_arbiter: RTL and testbench

Shares the single lower-cache (LC) port between the L1 data cache (L1D) and L1 instruction cache (L1I) requesters. The arbiter picks between line-sized read and writeback requests and drives them into a one-entry output buffer toward LC. It records each outstanding read in a small address-tagged table. When LC returns a line, the arbiter routes it to the requester that issued the read. It sits directly below both L1 caches, in place of a direct L1↔LC connection.

---
 rtl/l1_lc_arbiter.sv | 167 ++++++++++++++++
 tb/tb_l1_lc_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_lc_arbiter.sv
// Shares one LC port between L1D and L1I: one-entry request buffer, address-tagged read table, one-entry fill buffer.
// Define L1_LC_ARB_DPRIO_EN for fixed L1D priority; otherwise round-robin with a 1-bit last-grant pointer.
module l1_lc_arbiter #(
  parameter int PADDR_BITS  = 22,
  parameter int LINE_BITS   = 512,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  l1d_valid_in,
  output logic                  l1d_ready_out,
  input  logic [PADDR_BITS-1:0] l1d_addr_in,
  input  logic [LINE_BITS-1:0]  l1d_value_in,
  input  logic                  l1d_we_in,
  input  logic                  l1i_valid_in,
  output logic                  l1i_ready_out,
  input  logic [PADDR_BITS-1:0] l1i_addr_in,
  input  logic [LINE_BITS-1:0]  l1i_value_in,
  input  logic                  l1i_we_in,
  output logic                  l1d_resp_valid_out,
  input  logic                  l1d_resp_ready_in,
  output logic [PADDR_BITS-1:0] l1d_resp_addr_out,
  output logic [LINE_BITS-1:0]  l1d_resp_value_out,
  output logic                  l1i_resp_valid_out,
  input  logic                  l1i_resp_ready_in,
  output logic [PADDR_BITS-1:0] l1i_resp_addr_out,
  output logic [LINE_BITS-1:0]  l1i_resp_value_out,
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [PADDR_BITS-1:0] lc_addr_out,
  output logic [LINE_BITS-1:0]  lc_value_out,
  output logic                  lc_we_out,
  input  logic                  lc_valid_in,
  output logic                  lc_ready_out,
  input  logic [PADDR_BITS-1:0] lc_addr_in,
  input  logic [LINE_BITS-1:0]  lc_value_in,
  output logic                  err_unmatched_out
);
  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam int LW  = PADDR_BITS - OFF;
  localparam int IW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic                   req_full;
  logic                   rsp_full;
  logic                   rsp_id;
  logic [PADDR_BITS-1:0]  rsp_addr;
  logic [LINE_BITS-1:0]   rsp_value;
  logic [OUTSTANDING-1:0] tbl_vld;
  logic [OUTSTANDING-1:0] tbl_id;
  logic [LW-1:0]          tbl_line [OUTSTANDING];

  logic          req_avail, elig_d, elig_i, gnt_d, gnt_i, accept, alloc, sel_we;
  logic          dup_d, dup_i, tbl_free, hit_any, rsp_drain, rsp_capture;
  logic [IW-1:0] free_idx, hit_idx;
  logic [LW-1:0] line_d, line_i, line_rsp;

  assign line_d   = l1d_addr_in[PADDR_BITS-1:OFF];
  assign line_i   = l1i_addr_in[PADDR_BITS-1:OFF];
  assign line_rsp = lc_addr_in[PADDR_BITS-1:OFF];
  assign tbl_free = ~&tbl_vld;

  // Downward scan so the lowest free / matching index wins.
  always_comb begin
    dup_d    = 1'b0;
    dup_i    = 1'b0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (!tbl_vld[i]) free_idx = IW'(i);
      if (tbl_vld[i] && tbl_line[i] == line_d) dup_d = 1'b1;
      if (tbl_vld[i] && tbl_line[i] == line_i) dup_i = 1'b1;
      if (tbl_vld[i] && tbl_line[i] == line_rsp) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign req_avail = ~req_full | lc_ready_in;
  assign elig_d    = l1d_valid_in & req_avail & (l1d_we_in | (tbl_free & ~dup_d));
  assign elig_i    = l1i_valid_in & req_avail & (l1i_we_in | (tbl_free & ~dup_i));

`ifdef L1_LC_ARB_DPRIO_EN
  assign gnt_d = elig_d;
  assign gnt_i = elig_i & ~elig_d;
`else
  logic rr_ptr;  // 0 favours L1D, 1 favours L1I
  assign gnt_d = elig_d & (~elig_i | ~rr_ptr);
  assign gnt_i = elig_i & (~elig_d | rr_ptr);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= gnt_d;
  end
`endif

  assign l1d_ready_out = gnt_d;
  assign l1i_ready_out = gnt_i;
  assign accept        = gnt_d | gnt_i;
  assign sel_we        = gnt_d ? l1d_we_in : l1i_we_in;
  assign alloc         = accept & ~sel_we;
  assign lc_valid_out  = req_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_full     <= 1'b0;
      lc_addr_out  <= '0;
      lc_value_out <= '0;
      lc_we_out    <= 1'b0;
    end else if (accept) begin
      req_full     <= 1'b1;
      lc_addr_out  <= gnt_d ? l1d_addr_in : l1i_addr_in;
      lc_value_out <= gnt_d ? l1d_value_in : l1i_value_in;
      lc_we_out    <= sel_we;
    end else if (lc_ready_in) begin
      req_full <= 1'b0;
    end
  end

  assign rsp_drain    = rsp_full & (rsp_id ? l1i_resp_ready_in : l1d_resp_ready_in);
  assign lc_ready_out = ~rsp_full | rsp_drain;
  assign rsp_capture  = lc_valid_in & lc_ready_out;

  // Allocation targets a free slot and retirement a valid one, so both may act on the same edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tbl_vld <= '0;
      tbl_id  <= '0;
      for (int i = 0; i < OUTSTANDING; i++) tbl_line[i] <= '0;
    end else begin
      if (alloc) begin
        tbl_vld[free_idx]  <= 1'b1;
        tbl_id[free_idx]   <= gnt_i;
        tbl_line[free_idx] <= gnt_d ? line_d : line_i;
      end
      if (rsp_capture && hit_any) tbl_vld[hit_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsp_full          <= 1'b0;
      rsp_id            <= 1'b0;
      rsp_addr          <= '0;
      rsp_value         <= '0;
      err_unmatched_out <= 1'b0;
    end else begin
      if (rsp_capture && hit_any) begin
        rsp_full  <= 1'b1;
        rsp_id    <= tbl_id[hit_idx];
        rsp_addr  <= lc_addr_in;
        rsp_value <= lc_value_in;
      end else if (rsp_drain) begin
        rsp_full <= 1'b0;
      end
      if (rsp_capture && !hit_any) err_unmatched_out <= 1'b1;
    end
  end

  assign l1d_resp_valid_out = rsp_full & ~rsp_id;
  assign l1i_resp_valid_out = rsp_full & rsp_id;
  assign l1d_resp_addr_out  = rsp_addr;
  assign l1i_resp_addr_out  = rsp_addr;
  assign l1d_resp_value_out = rsp_value;
  assign l1i_resp_value_out = rsp_value;
endmodule

// File: tb/tb_l1_lc_arbiter.sv
// Scoreboarded bench for l1_lc_arbiter: expected LC requests and fills are queued on stimulus and checked on output.
module tb_l1_lc_arbiter;
  logic         clk = 1'b0;
  logic         rst_in;
  logic         l1d_valid_in, l1d_ready_out, l1d_we_in;
  logic [21:0]  l1d_addr_in;
  logic [511:0] l1d_value_in;
  logic         l1i_valid_in, l1i_ready_out, l1i_we_in;
  logic [21:0]  l1i_addr_in;
  logic [511:0] l1i_value_in;
  logic         l1d_resp_valid_out, l1d_resp_ready_in;
  logic [21:0]  l1d_resp_addr_out;
  logic [511:0] l1d_resp_value_out;
  logic         l1i_resp_valid_out, l1i_resp_ready_in;
  logic [21:0]  l1i_resp_addr_out;
  logic [511:0] l1i_resp_value_out;
  logic         lc_valid_out, lc_ready_in, lc_we_out;
  logic [21:0]  lc_addr_out;
  logic [511:0] lc_value_out;
  logic         lc_valid_in, lc_ready_out;
  logic [21:0]  lc_addr_in;
  logic [511:0] lc_value_in;
  logic         err_unmatched_out;

  int checks = 0;
  int passes = 0;

  typedef struct { logic [21:0] addr; logic we; logic [511:0] value; } lc_exp_t;
  typedef struct { logic id; logic [21:0] addr; logic [511:0] value; } fill_exp_t;
  lc_exp_t   exp_lc[$];
  fill_exp_t exp_fill[$];
  lc_exp_t   mon_e;
  fill_exp_t mon_f;

  always #5 clk = ~clk;

  l1_lc_arbiter dut (
    .clk_in(clk), .rst_in(rst_in),
    .l1d_valid_in(l1d_valid_in), .l1d_ready_out(l1d_ready_out), .l1d_addr_in(l1d_addr_in),
    .l1d_value_in(l1d_value_in), .l1d_we_in(l1d_we_in),
    .l1i_valid_in(l1i_valid_in), .l1i_ready_out(l1i_ready_out), .l1i_addr_in(l1i_addr_in),
    .l1i_value_in(l1i_value_in), .l1i_we_in(l1i_we_in),
    .l1d_resp_valid_out(l1d_resp_valid_out), .l1d_resp_ready_in(l1d_resp_ready_in),
    .l1d_resp_addr_out(l1d_resp_addr_out), .l1d_resp_value_out(l1d_resp_value_out),
    .l1i_resp_valid_out(l1i_resp_valid_out), .l1i_resp_ready_in(l1i_resp_ready_in),
    .l1i_resp_addr_out(l1i_resp_addr_out), .l1i_resp_value_out(l1i_resp_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
    .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
    .lc_value_in(lc_value_in), .err_unmatched_out(err_unmatched_out)
  );

  // Monitor: pop and compare outputs first, then queue newly accepted requests.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (lc_valid_out && lc_ready_in) begin
        checks++;
        if (exp_lc.size() == 0) $display("FAIL lc_req: unexpected request addr %h", lc_addr_out);
        else begin
          mon_e = exp_lc.pop_front();
          if (lc_addr_out !== mon_e.addr || lc_we_out !== mon_e.we || lc_value_out !== mon_e.value)
            $display("FAIL lc_req: got addr %h we %b val %h, want addr %h we %b val %h",
                     lc_addr_out, lc_we_out, lc_value_out[63:0], mon_e.addr, mon_e.we, mon_e.value[63:0]);
          else passes++;
        end
      end
      if (l1d_resp_valid_out && l1d_resp_ready_in) begin
        checks++;
        if (exp_fill.size() == 0) $display("FAIL fill_d: unexpected fill addr %h", l1d_resp_addr_out);
        else begin
          mon_f = exp_fill.pop_front();
          if (mon_f.id !== 1'b0 || l1d_resp_addr_out !== mon_f.addr || l1d_resp_value_out !== mon_f.value)
            $display("FAIL fill_d: got L1D addr %h val %h, want id %0d addr %h val %h",
                     l1d_resp_addr_out, l1d_resp_value_out[63:0], mon_f.id, mon_f.addr, mon_f.value[63:0]);
          else passes++;
        end
      end
      if (l1i_resp_valid_out && l1i_resp_ready_in) begin
        checks++;
        if (exp_fill.size() == 0) $display("FAIL fill_i: unexpected fill addr %h", l1i_resp_addr_out);
        else begin
          mon_f = exp_fill.pop_front();
          if (mon_f.id !== 1'b1 || l1i_resp_addr_out !== mon_f.addr || l1i_resp_value_out !== mon_f.value)
            $display("FAIL fill_i: got L1I addr %h val %h, want id %0d addr %h val %h",
                     l1i_resp_addr_out, l1i_resp_value_out[63:0], mon_f.id, mon_f.addr, mon_f.value[63:0]);
          else passes++;
        end
      end
      if (l1d_valid_in && l1d_ready_out) exp_lc.push_back('{l1d_addr_in, l1d_we_in, l1d_value_in});
      if (l1i_valid_in && l1i_ready_out) exp_lc.push_back('{l1i_addr_in, l1i_we_in, l1i_value_in});
    end
  end

  task automatic apply_reset;
    rst_in = 1'b1;
    l1d_valid_in = 1'b0; l1i_valid_in = 1'b0; lc_valid_in = 1'b0;
    lc_ready_in = 1'b1; l1d_resp_ready_in = 1'b1; l1i_resp_ready_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    exp_lc.delete();
    exp_fill.delete();
  endtask

  task automatic issue(input bit side, input logic [21:0] a, input logic we, input logic [511:0] v,
                       input int budget, output bit ok);
    if (!side) begin l1d_valid_in = 1'b1; l1d_addr_in = a; l1d_we_in = we; l1d_value_in = v; end
    else       begin l1i_valid_in = 1'b1; l1i_addr_in = a; l1i_we_in = we; l1i_value_in = v; end
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = side ? l1i_ready_out : l1d_ready_out;
      @(posedge clk); #1;
    end
    if (!side) l1d_valid_in = 1'b0; else l1i_valid_in = 1'b0;
  endtask

  task automatic send_rsp(input logic [21:0] a, input logic [511:0] v, input bit hit, input bit id,
                          input int budget, output bit ok);
    lc_valid_in = 1'b1; lc_addr_in = a; lc_value_in = v;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = lc_ready_out;
      if (ok && hit) exp_fill.push_back('{id, a, v});
      @(posedge clk); #1;
    end
    lc_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_lc.size() != 0 || exp_fill.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_lc.size() != 0 || exp_fill.size() != 0)
      $display("FAIL %s: %0d requests and %0d fills still pending, want 0", name, exp_lc.size(), exp_fill.size());
    else passes++;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lc_valid_out, lc_ready_out, l1d_ready_out, l1i_ready_out, l1d_resp_valid_out,
         l1i_resp_valid_out, lc_we_out, err_unmatched_out} !== 8'b0100_0000)
      $display("FAIL reset_ctl: got %b want 01000000", {lc_valid_out, lc_ready_out, l1d_ready_out,
               l1i_ready_out, l1d_resp_valid_out, l1i_resp_valid_out, lc_we_out, err_unmatched_out});
    else passes++;
    checks++;
    if (lc_addr_out !== 22'h0 || lc_value_out !== 512'h0 || l1d_resp_addr_out !== 22'h0 ||
        l1i_resp_value_out !== 512'h0)
      $display("FAIL reset_data: got lc_addr %h resp_addr %h want 0", lc_addr_out, l1d_resp_addr_out);
    else passes++;
    @(posedge clk); #1;
    rst_in = 1'b0;
    checks++;
    if (lc_valid_out !== 1'b0 || lc_ready_out !== 1'b1)
      $display("FAIL reset_release: got lc_valid %b lc_ready %b want 0 1", lc_valid_out, lc_ready_out);
    else passes++;
  endtask

  task automatic test_single_read;
    bit ok;
    apply_reset;
    issue(1'b0, 22'h2000, 1'b0, 512'h0, 5, ok);
    checks++; if (!ok) $display("FAIL single_accept: ready 0 want 1"); else passes++;
    checks++;
    if (lc_valid_out !== 1'b1 || lc_addr_out !== 22'h2000 || lc_we_out !== 1'b0)
      $display("FAIL single_latency: got valid %b addr %h we %b want 1 002000 0", lc_valid_out, lc_addr_out, lc_we_out);
    else passes++;
    wait_drain("single_req", 10);
    send_rsp(22'h2000, 512'hDEADBEEF, 1'b1, 1'b0, 5, ok);
    checks++; if (!ok) $display("FAIL single_rsp_accept: lc_ready 0 want 1"); else passes++;
    checks++;
    if (l1d_resp_valid_out !== 1'b1 || l1d_resp_value_out !== 512'hDEADBEEF || l1i_resp_valid_out !== 1'b0)
      $display("FAIL single_fill: got d_vld %b val %h i_vld %b want 1 deadbeef 0",
               l1d_resp_valid_out, l1d_resp_value_out[63:0], l1i_resp_valid_out);
    else passes++;
    wait_drain("single_fill", 10);
  endtask

  task automatic test_round_robin;
    bit ok, want_i, got_i;
    logic [21:0] da, ia;
    logic [21:0] ga[$];
    bit gi[$];
    apply_reset;
    da = 22'h1000; ia = 22'h3000;
    l1d_valid_in = 1'b1; l1d_addr_in = da; l1d_we_in = 1'b0; l1d_value_in = 512'h0;
    l1i_valid_in = 1'b1; l1i_addr_in = ia; l1i_we_in = 1'b0; l1i_value_in = 512'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef L1_LC_ARB_DPRIO_EN
      want_i = 1'b0;
`else
      want_i = k[0];
`endif
      @(negedge clk);
      got_i = l1i_ready_out;
      checks++;
      if ({l1d_ready_out, l1i_ready_out} !== (want_i ? 2'b01 : 2'b10))
        $display("FAIL rr_grant%0d: got d/i ready %b%b want %b", k, l1d_ready_out, l1i_ready_out,
                 want_i ? 2'b01 : 2'b10);
      else passes++;
      if (l1d_ready_out || l1i_ready_out) begin
        ga.push_back(got_i ? ia : da);
        gi.push_back(got_i);
      end
      @(posedge clk); #1;
      if (got_i) begin ia = ia + 22'h40; l1i_addr_in = ia; end
      else begin da = da + 22'h40; l1d_addr_in = da; end
    end
    l1d_valid_in = 1'b0; l1i_valid_in = 1'b0;
    wait_drain("rr_req", 10);
    foreach (ga[j]) begin
      send_rsp(ga[j], 512'(ga[j]) ^ 512'hA5A5, 1'b1, gi[j], 5, ok);
      checks++; if (!ok) $display("FAIL rr_rsp%0d: lc_ready 0 want 1", j); else passes++;
    end
    wait_drain("rr_fill", 10);
  endtask

  task automatic test_table_full;
    bit ok;
    apply_reset;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 22'((k + 1) * 64), 1'b0, 512'h0, 5, ok);
      checks++; if (!ok) $display("FAIL full_fill%0d: ready 0 want 1", k); else passes++;
    end
    l1i_valid_in = 1'b1; l1i_addr_in = 22'h140; l1i_we_in = 1'b0; l1i_value_in = 512'h0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (l1i_ready_out !== 1'b0) $display("FAIL full_stall: ready %b want 0", l1i_ready_out); else passes++;
      @(posedge clk); #1;
    end
    issue(1'b0, 22'h5000, 1'b1, 512'h5A5A, 5, ok);
    checks++; if (!ok) $display("FAIL full_wb: writeback ready 0 want 1"); else passes++;
    lc_valid_in = 1'b1; lc_addr_in = 22'h80; lc_value_in = 512'h80;
    @(negedge clk);
    checks++;
    if (lc_ready_out !== 1'b1 || l1i_ready_out !== 1'b0)
      $display("FAIL full_same_cycle: lc_ready %b i_ready %b want 1 0", lc_ready_out, l1i_ready_out);
    else passes++;
    exp_fill.push_back('{1'b0, 22'h80, 512'h80});
    @(posedge clk); #1;
    lc_valid_in = 1'b0;
    checks++; if (l1i_ready_out !== 1'b1) $display("FAIL full_retire: ready %b want 1", l1i_ready_out); else passes++;
    @(posedge clk); #1;
    l1i_valid_in = 1'b0;
    wait_drain("full_req", 10);
    send_rsp(22'h40, 512'h40, 1'b1, 1'b0, 5, ok);
    send_rsp(22'hC0, 512'hC0, 1'b1, 1'b0, 5, ok);
    send_rsp(22'h100, 512'h100, 1'b1, 1'b0, 5, ok);
    send_rsp(22'h140, 512'h140, 1'b1, 1'b1, 5, ok);
    wait_drain("full_fill", 10);
  endtask

  task automatic test_dup_line;
    bit ok;
    apply_reset;
    issue(1'b1, 22'h60300, 1'b0, 512'h0, 5, ok);
    checks++; if (!ok) $display("FAIL dup_first: ready 0 want 1"); else passes++;
    l1d_valid_in = 1'b1; l1d_addr_in = 22'h60320; l1d_we_in = 1'b0; l1d_value_in = 512'h0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (l1d_ready_out !== 1'b0) $display("FAIL dup_stall: ready %b want 0", l1d_ready_out); else passes++;
      @(posedge clk); #1;
    end
    issue(1'b1, 22'h60340, 1'b0, 512'h0, 5, ok);
    checks++; if (!ok) $display("FAIL dup_other_line: ready 0 want 1"); else passes++;
    send_rsp(22'h60300, 512'h603, 1'b1, 1'b1, 5, ok);
    checks++; if (l1d_ready_out !== 1'b1) $display("FAIL dup_release: ready %b want 1", l1d_ready_out); else passes++;
    @(posedge clk); #1;
    l1d_valid_in = 1'b0;
    wait_drain("dup_req", 10);
    send_rsp(22'h60340, 512'h6034, 1'b1, 1'b1, 5, ok);
    send_rsp(22'h60320, 512'h6032, 1'b1, 1'b0, 5, ok);
    wait_drain("dup_fill", 10);
  endtask

  task automatic test_fill_backpressure;
    bit ok;
    apply_reset;
    l1d_resp_ready_in = 1'b0;
    issue(1'b0, 22'h9000, 1'b0, 512'h0, 5, ok);
    issue(1'b1, 22'hA000, 1'b0, 512'h0, 5, ok);
    while (exp_lc.size() != 0 && !lc_valid_out) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    send_rsp(22'h9000, 512'h9, 1'b1, 1'b0, 5, ok);
    lc_valid_in = 1'b1; lc_addr_in = 22'hA000; lc_value_in = 512'hA;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({lc_ready_out, l1d_resp_valid_out, l1i_resp_valid_out} !== 3'b010)
        $display("FAIL bp_block: lc_ready/d_vld/i_vld %b want 010",
                 {lc_ready_out, l1d_resp_valid_out, l1i_resp_valid_out});
      else passes++;
      @(posedge clk); #1;
    end
    exp_fill.push_back('{1'b1, 22'hA000, 512'hA});
    l1d_resp_ready_in = 1'b1;
    @(negedge clk);
    checks++; if (lc_ready_out !== 1'b1) $display("FAIL bp_release: lc_ready %b want 1", lc_ready_out); else passes++;
    @(posedge clk); #1;
    lc_valid_in = 1'b0;
    wait_drain("bp_fill", 10);
  endtask

  task automatic test_unmatched;
    bit ok;
    apply_reset;
    checks++; if (err_unmatched_out !== 1'b0) $display("FAIL err_clear: err %b want 0", err_unmatched_out); else passes++;
    send_rsp(22'h7000, 512'h7, 1'b0, 1'b0, 5, ok);
    checks++;
    if (err_unmatched_out !== 1'b1 || l1d_resp_valid_out !== 1'b0 || l1i_resp_valid_out !== 1'b0)
      $display("FAIL err_set: err %b d_vld %b i_vld %b want 1 0 0", err_unmatched_out,
               l1d_resp_valid_out, l1i_resp_valid_out);
    else passes++;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (err_unmatched_out !== 1'b1) $display("FAIL err_sticky: err %b want 1", err_unmatched_out); else passes++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    apply_reset;
    issue(1'b0, 22'hB000, 1'b0, 512'h0, 5, ok);
    issue(1'b1, 22'hB040, 1'b0, 512'h0, 5, ok);
    wait_drain("mid_req", 10);
    lc_ready_in = 1'b0;
    issue(1'b0, 22'hC000, 1'b1, 512'hC, 5, ok);
    checks++; if (lc_valid_out !== 1'b1) $display("FAIL mid_req_full: lc_valid %b want 1", lc_valid_out); else passes++;
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if ({lc_valid_out, lc_ready_out, lc_we_out, err_unmatched_out} !== 4'b0100 ||
        lc_addr_out !== 22'h0 || lc_value_out !== 512'h0)
      $display("FAIL mid_async_reset: valid/ready/we/err %b addr %h want 0100 000000",
               {lc_valid_out, lc_ready_out, lc_we_out, err_unmatched_out}, lc_addr_out);
    else passes++;
    exp_lc.delete();
    lc_ready_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    send_rsp(22'hB000, 512'hB, 1'b0, 1'b0, 5, ok);
    checks++; if (err_unmatched_out !== 1'b1) $display("FAIL mid_lost_rsp: err %b want 1", err_unmatched_out); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    l1d_valid_in = 1'b0; l1d_addr_in = '0; l1d_value_in = '0; l1d_we_in = 1'b0;
    l1i_valid_in = 1'b0; l1i_addr_in = '0; l1i_value_in = '0; l1i_we_in = 1'b0;
    l1d_resp_ready_in = 1'b1; l1i_resp_ready_in = 1'b1;
    lc_ready_in = 1'b1; lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_table_full;
    test_dup_line;
    test_fill_backpressure;
    test_unmatched;
    test_reset_mid;
    wait_drain("final", 10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
